mac_pipe: RTL
=============

# mac_pipe

Parametrised, pipelined multiply-accumulate unit for the matrix-multiplier datapath. It generalises the 8×8 reduce/adder16 multiplier to WIDTH-bit operands, a configurable number of pipeline stages and per-group signed or unsigned mode. Products are accumulated over a group of beats terminated by `s_last`, so one group computes one dot product, which is one matrix element. Input and output use valid/ready handshakes with full backpressure.

## Interface
- `WIDTH`, default 8: operand width in bits; legal values are 2 to 16.
- `ACC_W`, default 2*WIDTH+4: accumulator and result width in bits; must be at least 2*WIDTH.
- `STAGES`, default 2: number of product pipeline register stages; legal values are 1 to 4.
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `s_valid` input, 1 bit: input beat valid.
- `s_ready` output, 1 bit: unit can accept a beat.
- `s_a` input, WIDTH bits: operand A.
- `s_b` input, WIDTH bits: operand B.
- `s_signed` input, 1 bit: 1 selects two's-complement operands; sampled only on the first beat of a group.
- `s_last` input, 1 bit: marks the final beat of a group.
- `m_valid` output, 1 bit: result valid.
- `m_ready` input, 1 bit: downstream accepts the result.
- `m_data` output, ACC_W bits: accumulated group result.
- `m_ovf` output, 1 bit: sticky overflow flag for the group, valid together with `m_data`.

## Operation
- A handshake occurs on a rising edge where `s_valid && s_ready`. On that edge the unit registers `a`, `b`, `last` and the group mode into stage 0.
- **Group mode.** A first-beat flag is set at reset and after each accepted `last` beat. On a first beat, `s_signed` is latched as the group mode. On later beats of the same group, `s_signed` is ignored.
- **Product width.** The product is 2*WIDTH bits. In signed mode it is computed signed and sign-extended to ACC_W. In unsigned mode it is zero-extended to ACC_W.
- **Product pipeline.** The product passes through STAGES registers. Each stage carries a valid bit, so bubbles never accumulate.
- **Accumulate edge.** On the edge where a valid beat leaves the last stage, the unit computes `sum = acc + ext_product`, which wraps modulo 2^ACC_W.
  - Overflow is detected per addition. In unsigned mode it is the carry out of bit ACC_W-1. In signed mode it is set when both operands have the same sign and the sum's sign differs.
  - If the beat is not last: `acc <= sum`, and `ovf_acc <= ovf_acc | ovf`.
  - If the beat is last: `m_data <= sum`, `m_ovf <= ovf_acc | ovf`, `m_valid <= 1`, `acc <= 0` and `ovf_acc <= 0`.
- **Stall.** `stall = m_valid && !m_ready`, and `s_ready = !rst && !stall`.
  - `s_ready` has a combinational path from `m_ready`.
  - While stalled, every pipeline register, `acc`, `m_data` and `m_ovf` hold their values.
- **Output retirement.** `m_valid` clears on the edge where `m_valid && m_ready`, unless a new last beat completes on that same edge, in which case `m_valid` stays 1 and `m_data` takes the new value.
- **Reset.** `rst` asserted at any time, including mid-group or mid-stall, clears everything: all stage valids, `acc`, `ovf_acc`, the first-beat flag (set to 1), `m_valid`, `m_data` and `m_ovf`. A partial group is discarded.

## Timing
- **Reset values.** `s_ready` = 0 while `rst` is high and 1 after release. `m_valid` = 0, `m_data` = 0, `m_ovf` = 0.
- **Latency.** If the last beat handshakes at edge k, `m_valid` is high after edge k+STAGES+1 when there is no stall. With STAGES=2 the result appears 3 cycles after the handshake.
- **Throughput.** One beat per cycle. A new group may start on the cycle immediately after a `last` beat.
- **Output stability.** `m_data` and `m_ovf` remain stable while `m_valid && !m_ready`.
- **Ordering.** Results emerge in group order. No beat is lost or duplicated under any `m_ready` pattern.
- **Single-beat groups.** `s_last` set on the first beat is legal. The result equals that beat's product.

## Test plan
- **Reset.** Hold `rst` high for 3 cycles with random inputs. Required: `s_ready`=0, `m_valid`=0, `m_data`=0, `m_ovf`=0. After release, `s_ready`=1.
- **Unsigned single beat.** Defaults, `m_ready`=1, one beat 0xFF×0xFF with `s_last`=1, `s_signed`=0. Required: `m_data`=65025 and `m_ovf`=0, exactly 3 cycles after the handshake.
- **Dot product with mode check.**
  - Unsigned beats (3,5), (7,9 last). Required: `m_data`=78.
  - Signed group (0xFE,0x03), (0x80,0x80 last) with `s_signed`=1 on the first beat and 0 on the second. Required: `m_data`=16378, proving the mode latched from the first beat. Both groups are sent back to back.
- **Backpressure.**
  - Stream 4 single-beat groups (1×1, 2×2, 3×3, 4×4) while holding `m_ready`=0. Required: `m_valid` rises and `s_ready` falls, with `m_data`=1 held.
  - Release `m_ready`. Required: results 1, 4, 9, 16 arrive in order with no loss.
- **Overflow, ACC_W=16 instance.**
  - Unsigned 0xFF×0xFF twice, last on the second. Required: `m_data`=64514 (130050 mod 65536) and `m_ovf`=1.
  - Signed 0x80×0x80 twice. Required: `m_data`=0x8000 and `m_ovf`=1.
- **Reset mid-group.** Accept beat (10,10) without last, pulse `rst`, then send (2,3 last). Required: `m_data`=6, showing the partial sum was discarded.

Source files
------------

// File: rtl/mac_pipe.sv
// Pipelined multiply-accumulate unit: WIDTH-bit operands, STAGES product registers,
// group accumulation terminated by s_last, valid/ready on both sides with full backpressure.
module mac_pipe #(
  parameter int WIDTH  = 8,
  parameter int ACC_W  = 2*WIDTH+4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_a,
  input  logic [WIDTH-1:0] s_b,
  input  logic             s_signed,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [ACC_W-1:0] m_data,
  output logic             m_ovf
);

  localparam int PW = 2*WIDTH;

  logic             stall;
  logic             fire_in;
  logic             first;
  logic             mode_r;
  logic             beat_mode;

  logic             s0_valid;
  logic             s0_last;
  logic             s0_mode;
  logic [WIDTH-1:0] s0_a;
  logic [WIDTH-1:0] s0_b;

  logic signed [PW-1:0] a_sx;
  logic signed [PW-1:0] b_sx;
  logic signed [PW-1:0] prod_s;
  logic        [PW-1:0] prod_u;
  logic     [ACC_W-1:0] prod_ext;

  logic [STAGES-1:0] p_valid;
  logic [STAGES-1:0] p_last;
  logic [STAGES-1:0] p_mode;
  logic  [ACC_W-1:0] p_data [STAGES];

  logic             tail_valid;
  logic             tail_last;
  logic             tail_mode;
  logic [ACC_W-1:0] tail_data;

  logic [ACC_W-1:0] acc;
  logic             ovf_acc;
  logic   [ACC_W:0] sum_c;
  logic [ACC_W-1:0] sum;
  logic             ovf;

  assign stall     = m_valid && !m_ready;
  assign s_ready   = !rst && !stall;
  assign fire_in   = s_valid && s_ready;
  // The mode of the first beat in a group governs every later beat of that group.
  assign beat_mode = first ? s_signed : mode_r;

  assign tail_valid = p_valid[STAGES-1];
  assign tail_last  = p_last[STAGES-1];
  assign tail_mode  = p_mode[STAGES-1];
  assign tail_data  = p_data[STAGES-1];

  // Product computed from the operand register, extended to accumulator width.
  always_comb begin
    a_sx     = PW'($signed(s0_a));
    b_sx     = PW'($signed(s0_b));
    prod_s   = a_sx * b_sx;
    prod_u   = PW'(s0_a) * PW'(s0_b);
    prod_ext = s0_mode ? ACC_W'(prod_s) : ACC_W'(prod_u);
  end

  // Accumulator addition with per-mode overflow detection.
  always_comb begin
    sum_c = {1'b0, acc} + {1'b0, tail_data};
    sum   = sum_c[ACC_W-1:0];
    ovf   = tail_mode ? ((acc[ACC_W-1] == tail_data[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]))
                      : sum_c[ACC_W];
  end

  // Operand register, group-mode tracking and product pipeline; all frozen while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first    <= 1'b1;
      mode_r   <= 1'b0;
      s0_valid <= 1'b0;
      s0_last  <= 1'b0;
      s0_mode  <= 1'b0;
      s0_a     <= '0;
      s0_b     <= '0;
      p_valid  <= '0;
      p_last   <= '0;
      p_mode   <= '0;
      for (int i = 0; i < STAGES; i++) p_data[i] <= '0;
    end else if (!stall) begin
      s0_valid <= fire_in;
      if (fire_in) begin
        s0_a    <= s_a;
        s0_b    <= s_b;
        s0_last <= s_last;
        s0_mode <= beat_mode;
        mode_r  <= beat_mode;
        first   <= s_last;
      end
      p_valid[0] <= s0_valid;
      p_last[0]  <= s0_last;
      p_mode[0]  <= s0_mode;
      p_data[0]  <= prod_ext;
      for (int i = 1; i < STAGES; i++) begin
        p_valid[i] <= p_valid[i-1];
        p_last[i]  <= p_last[i-1];
        p_mode[i]  <= p_mode[i-1];
        p_data[i]  <= p_data[i-1];
      end
    end
  end

  // Accumulation and result register; m_valid drops on retirement unless a new result lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      ovf_acc <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ovf   <= 1'b0;
    end else if (!stall) begin
      m_valid <= tail_valid && tail_last;
      if (tail_valid && tail_last) begin
        m_data  <= sum;
        m_ovf   <= ovf_acc | ovf;
        acc     <= '0;
        ovf_acc <= 1'b0;
      end else if (tail_valid) begin
        acc     <= sum;
        ovf_acc <= ovf_acc | ovf;
      end
    end
  end

endmodule
